// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: redirect, instruction-memory and decode-side signals of the fetch queue.
interface ifetch_queue_if;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_read;
   logic [31:0] imem_addr;
   logic        imem_resp;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   modport master (
      output redirect, redirect_pc, imem_resp, imem_rdata, inst_ready,
      input  imem_read, imem_addr, inst_valid, inst_data, inst_pc
   );
   modport slave (
      input  redirect, redirect_pc, imem_resp, imem_rdata, inst_ready,
      output imem_read, imem_addr, inst_valid, inst_data, inst_pc
   );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: single-outstanding instruction fetcher feeding a circular instruction queue.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
   input logic           clk,
   input logic           rst,
   ifetch_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];
   typedef enum logic [1:0] {IDLE, BUSY, SQUASH} state_t;
   state_t      r_state, w_next_state;
   logic [31:0] r_fetch_pc, w_fetch_pc_next, r_req_addr;
   logic [31:0] r_data [DEPTH];
   logic [31:0] r_pc   [DEPTH];
   logic [AW-1:0] r_head, r_tail;
   logic [AW:0]   r_count, w_count_next;
   logic          w_valid, w_push, w_pop;
   assign w_valid         = (r_count != '0) && !bus.redirect;
   assign w_pop           = w_valid && bus.inst_ready;
   assign w_push          = (r_state == BUSY) && bus.imem_resp && !bus.redirect;
   assign w_count_next    = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
   assign w_fetch_pc_next = bus.redirect ? bus.redirect_pc : w_push ? r_fetch_pc + 32'd4 : r_fetch_pc;
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end
   // SQUASH waits out the abandoned request; a response there always ends it
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    w_next_state = (!bus.redirect && r_count < FULL) ? BUSY : IDLE;
         BUSY:    w_next_state = bus.redirect ? (bus.imem_resp ? IDLE : SQUASH)
                               : bus.imem_resp ? (w_count_next < FULL ? BUSY : IDLE) : BUSY;
         SQUASH:  w_next_state = bus.imem_resp ? IDLE : SQUASH;
         default: w_next_state = IDLE;
      endcase
   end
   always_comb begin
      bus.imem_read  = r_state != IDLE;
      bus.imem_addr  = r_req_addr;
      bus.inst_valid = w_valid;
      bus.inst_data  = r_data[r_head];
      bus.inst_pc    = r_pc[r_head];
   end
   // the request address only moves when a new request is launched
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_req_addr <= '0;
      end else begin
         r_fetch_pc <= w_fetch_pc_next;
         if (w_next_state == BUSY) r_req_addr <= w_fetch_pc_next;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (bus.redirect) begin
         r_head  <= r_tail;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         r_count <= w_count_next;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
            r_pc[i]   <= '0;
         end
      end else if (w_push) begin
         r_data[r_tail] <= bus.imem_rdata;
         r_pc[r_tail]   <= r_req_addr;
      end
   end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed and random fetch traffic checked against a queue-based reference model.
module tb_ifetch_queue;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h6000_0000;
   typedef struct packed {logic [31:0] d; logic [31:0] pc;} ent_t;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   ifetch_queue_if bus();
   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0;
   int errors = 0;
   ent_t q[$];
   bit m_out, m_sq;
   logic [31:0] m_fpc, m_addr;
   int wait_cnt = 0, lat = 0, lat_min = 0, lat_max = 0;
   bit stray = 0, use_fixed = 0;
   logic [31:0] fixed_data = 32'h13;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      q.delete();
      m_fpc = RST_PC;
      m_out = 0;
      m_sq  = 0;
   endtask
   task automatic model_edge(input bit r, input bit rd, input logic [31:0] rpc, input bit rsp,
                             input logic [31:0] rdat, input bit rdy);
      bit was_idle;
      bit pop;
      bit issue;
      int pre;
      if (r) begin
         model_reset();
      end else begin
         was_idle = !m_out;
         pre      = q.size();
         pop      = (pre != 0) && !rd && rdy;
         issue    = 0;
         if (rd) begin
            q.delete();
            m_fpc = rpc;
            if (m_out && rsp) begin
               m_out = 0;
               m_sq  = 0;
            end else if (m_out) m_sq = 1;
         end else begin
            if (pop) void'(q.pop_front());
            if (m_out && rsp) begin
               if (!m_sq) begin
                  q.push_back('{d: rdat, pc: m_addr});
                  m_fpc = m_fpc + 32'd4;
                  issue = q.size() < DEPTH;
               end
               m_out = 0;
               m_sq  = 0;
            end
            if (was_idle && pre < DEPTH) issue = 1;
            if (issue) begin
               m_out  = 1;
               m_addr = m_fpc;
            end
         end
      end
   endtask
   task automatic cycle(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy);
      bit rsp;
      bit exp_v;
      logic [31:0] rdat;
      rsp  = 0;
      rdat = use_fixed ? fixed_data : $urandom;
      if (!r && bus.imem_read) begin
         if (wait_cnt >= lat) begin
            rsp      = 1;
            wait_cnt = 0;
            lat      = $urandom_range(lat_max, lat_min);
         end else wait_cnt++;
      end
      if (stray) begin
         rsp   = 1;
         stray = 0;
      end
      if (r) wait_cnt = 0;
      rst             = r;
      bus.redirect    = rd;
      bus.redirect_pc = rpc;
      bus.inst_ready  = rdy;
      bus.imem_resp   = rsp;
      bus.imem_rdata  = rdat;
      #1;
      exp_v = (q.size() != 0) && !rd;
      chk("imem_read", {31'd0, bus.imem_read}, {31'd0, m_out});
      if (m_out) chk("imem_addr", bus.imem_addr, m_addr);
      chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, exp_v});
      if (exp_v) begin
         chk("inst_data", bus.inst_data, q[0].d);
         chk("inst_pc", bus.inst_pc, q[0].pc);
      end
      @(posedge clk);
      model_edge(r, rd, rpc, rsp, rdat, rdy);
      #1;
   endtask
   initial begin
      logic [31:0] rv;
      rst = 1;
      bus.redirect = 0; bus.redirect_pc = '0; bus.inst_ready = 0;
      bus.imem_resp = 0; bus.imem_rdata = '0;
      @(posedge clk);
      #1;
      model_reset();
      cycle(1, 0, '0, 1);
      chk("rst_read", {31'd0, bus.imem_read}, 32'd0);
      chk("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
      chk("rst_data", bus.inst_data, 32'd0);
      chk("rst_pc", bus.inst_pc, 32'd0);
      // reset release, single-cycle memory, decode always ready
      use_fixed = 1;
      cycle(0, 0, '0, 1);
      chk("first_read", {31'd0, bus.imem_read}, 32'd1);
      chk("first_addr", bus.imem_addr, RST_PC);
      for (int i = 0; i < 8; i++) cycle(0, 0, '0, 1);
      chk("stream_pc", bus.inst_pc, RST_PC + 32'd28);
      // decode stalled until the queue fills
      cycle(1, 0, '0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, '0, 0);
      chk("full_read", {31'd0, bus.imem_read}, 32'd0);
      chk("full_head", bus.inst_pc, RST_PC);
      for (int i = 0; i < 6; i++) cycle(0, 0, '0, 1);
      // redirect while the response is still three cycles away
      use_fixed = 0;
      cycle(1, 0, '0, 0);
      lat = 3; lat_min = 3; lat_max = 3;
      cycle(0, 0, '0, 0);
      cycle(0, 1, 32'h6000_0100, 0);
      chk("squash_addr", bus.imem_addr, RST_PC);
      chk("squash_valid", {31'd0, bus.inst_valid}, 32'd0);
      for (int i = 0; i < 6; i++) cycle(0, 0, '0, 1);
      // redirect coincident with a response
      lat = 0; lat_min = 0; lat_max = 0;
      for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1);
      cycle(0, 1, 32'h6000_0100, 1);
      chk("coin_valid", {31'd0, bus.inst_valid}, 32'd0);
      cycle(0, 0, '0, 1);
      chk("coin_addr", bus.imem_addr, 32'h6000_0100);
      // two entries queued, then push and pop together
      cycle(0, 0, '0, 0);
      cycle(0, 0, '0, 0);
      cycle(0, 0, '0, 1);
      cycle(0, 0, '0, 1);
      // fetch address wraps past the top of memory
      cycle(0, 1, 32'hFFFF_FFF8, 1);
      for (int i = 0; i < 6; i++) cycle(0, 0, '0, 1);
      // reset in the middle of a request, then a late response
      lat = 3; lat_min = 3; lat_max = 3;
      cycle(0, 0, '0, 1);
      cycle(1, 0, '0, 1);
      chk("midrst_read", {31'd0, bus.imem_read}, 32'd0);
      chk("midrst_valid", {31'd0, bus.inst_valid}, 32'd0);
      stray = 1;
      cycle(0, 0, '0, 1);
      chk("midrst_addr", bus.imem_addr, RST_PC);
      for (int i = 0; i < 6; i++) cycle(0, 0, '0, 1);
      // random traffic
      lat_min = 0; lat_max = 3;
      for (int i = 0; i < 800; i++) begin
         rv = $urandom;
         rv[1:0] = 2'b00;
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0, rv, $urandom_range(0, 3) != 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction-queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h6000_0000, fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 redirect  input  1  flush queue and restart fetch at redirect_pc.
REQ-006 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-007 imem_read  output  1  instruction-memory read request, held until imem_resp.
REQ-008 imem_addr  output  32  read address, stable while imem_read=1.
REQ-009 imem_resp  input  1  memory response valid, one cycle per request.
REQ-010 imem_rdata  input  32  instruction word, valid when imem_resp=1.
REQ-011 inst_valid  output  1  head entry available to decode.
REQ-012 inst_ready  input  1  decode accepts head (drives instruction-register load).
REQ-013 inst_data  output  32  head instruction word.
REQ-014 inst_pc  output  32  address of the head instruction.

Function
REQ-015 The block SHALL hold at most one outstanding memory request.
REQ-016 The block SHALL implement states IDLE, BUSY, SQUASH; imem_read SHALL be 1 exactly in BUSY and SQUASH.
REQ-017 imem_addr SHALL come from a request-address register loaded with fetch_pc on each IDLE->BUSY or BUSY->BUSY transition, and held otherwise.
REQ-018 IDLE: no redirect and count<DEPTH -> BUSY; redirect -> fetch_pc<=redirect_pc, queue flushed, stay IDLE.
REQ-019 BUSY, imem_resp=1, no redirect: push {imem_rdata, imem_addr}, fetch_pc<=fetch_pc+4 (mod 2^32); -> BUSY if post-update count<DEPTH, else IDLE.
REQ-020 BUSY, redirect with imem_resp=1: response discarded, queue flushed, fetch_pc<=redirect_pc, -> IDLE.
REQ-021 BUSY, redirect with imem_resp=0: queue flushed, fetch_pc<=redirect_pc, -> SQUASH; imem_addr held at the old address.
REQ-022 SQUASH: on imem_resp, data discarded, -> IDLE; a further redirect updates fetch_pc and stays SQUASH.
REQ-023 Queue SHALL be a circular buffer with head/tail pointers wrapping modulo DEPTH and count 0..DEPTH.
REQ-024 inst_valid SHALL equal (count!=0) && !redirect; inst_data/inst_pc SHALL show the head entry.
REQ-025 Pop occurs when inst_valid && inst_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-026 Redirect SHALL take precedence over push and pop: count<=0, head<=tail.
REQ-027 Issue only at count<DEPTH SHALL guarantee push never overflows; no bypass, so a response is visible on inst_valid one cycle after imem_resp.
REQ-028 Throughput SHALL be one instruction per cycle with single-cycle memory and inst_ready=1.

Reset
REQ-029 On rst: state IDLE, fetch_pc=RESET_PC, count=0, pointers 0, storage 0; imem_read=0, inst_valid=0, inst_data=0, inst_pc=0 the cycle after rst is sampled.
REQ-030 rst during BUSY/SQUASH SHALL abandon the request; the late response SHALL be ignored.
REQ-031 First rising edge with rst=0 SHALL move IDLE->BUSY, so imem_read=1 with imem_addr=RESET_PC in the following cycle.

Verification
REQ-032 Reset release, 1-cycle memory returning 0x00000013, inst_ready=1 -> requests 0x60000000, 0x60000004, ... back-to-back; inst_pc sequence identical, one per cycle.
REQ-033 inst_ready=0, 1-cycle memory -> after 4 pushes imem_read=0, count=4, head inst_pc=0x60000000; raise inst_ready -> pops 0x60000000..0x6000000C in order, next request at 0x60000010.
REQ-034 Redirect to 0x60000100 in BUSY, response delayed 3 cycles -> imem_addr holds old address until imem_resp, data discarded, inst_valid=0, next request 0x60000100.
REQ-035 Redirect to 0x60000100 coincident with imem_resp -> no push, inst_valid=0 that cycle, next request 0x60000100.
REQ-036 count=2, push and pop in the same cycle -> count stays 2, head advances by one, new entry at tail.
REQ-037 rst asserted mid-BUSY -> next cycle imem_read=0, inst_valid=0; after release first request at 0x60000000.
